b3_timer_ctrl: RTL and testbench

B3_TIMER_CTRL -- requirements
Module: b3_timer_ctrl

---
 rtl/b3_pkg.sv | 50 +++++
 rtl/b3_digit.sv | 35 +++
 rtl/b3_timer_ctrl.sv | 106 ++++++++++
 tb/tb_b3_timer_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/b3_pkg.sv
// Shared definitions for the base-3 timer: digit geometry, FSM states and
// small helpers for validating and incrementing a base-3 count.
package b3_pkg;

  localparam int unsigned DIGIT_W = 2;
  localparam int unsigned NDIG    = 3;
  localparam int unsigned CNT_W   = DIGIT_W * NDIG;

  localparam logic [DIGIT_W-1:0] DIG_INVALID = 2'b11;
  localparam logic [DIGIT_W-1:0] DIG_MAX     = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // True when no digit carries the invalid code.
  function automatic logic tc_valid(input logic [CNT_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] == DIG_INVALID) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Base-3 increment by one; mirrors the digit chain so the terminal match
  // can be decided on the same edge that produces the new count.
  function automatic logic [CNT_W-1:0] b3_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (c) begin
        if (v[i*DIGIT_W +: DIGIT_W] == DIG_MAX) begin
          r[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 1'b1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/b3_digit.sv
// One base-3 counter digit: counts 0,1,2,0... when enabled and emits a carry
// (eu) on the enabled 2->0 wrap to enable the next digit.
module b3_digit
  import b3_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               ei,
  output logic               eu,
  output logic [DIGIT_W-1:0] q
);

  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (ei) begin
      q_d = (q == DIG_MAX) ? '0 : q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

  assign eu = ei & (q == DIG_MAX);

endmodule

// File: rtl/b3_timer_ctrl.sv
// Base-3 run timer: counts from 0 up to a latched terminal count, then waits
// in DONE for ack. Abort clears back to IDLE from RUN or DONE.
module b3_timer_ctrl
  import b3_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] tc,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic             err_q, err_d;
  logic             clr;
  logic             inc;
  logic [NDIG:0]    carry;
  logic [CNT_W-1:0] count_inc;
  logic             unused_carry;

  assign count_inc = b3_inc(count);

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (tc_valid(tc)) begin
            tc_d    = tc;
            clr     = 1'b1;
            state_d = (tc == '0) ? StDone : StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = StIdle;
        end else if (!pause) begin
          inc = 1'b1;
          if (count_inc == tc_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = StIdle;
        end else if (ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign carry[0] = inc;

  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    b3_digit u_digit (
      .clock (clock),
      .reset (reset),
      .clr   (clr),
      .ei    (carry[i]),
      .eu    (carry[i+1]),
      .q     (count[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Top-digit carry cannot fire for any valid terminal count.
  assign unused_carry = carry[NDIG];

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign err  = err_q;

endmodule

// File: tb/tb_b3_timer_ctrl.sv
// Directed bench for b3_timer_ctrl: run, pause, invalid tc, full-range carries,
// zero terminal count, reset and abort.
module tb_b3_timer_ctrl;

  logic       clock = 1'b0;
  logic       reset, start, pause, abort, ack;
  logic [5:0] tc;
  logic [5:0] count;
  logic       busy, done, err;

  int checks   = 0;
  int failures = 0;

  b3_timer_ctrl dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .tc    (tc),
    .pause (pause),
    .abort (abort),
    .ack   (ack),
    .count (count),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] to_b3(input int v);
    logic [1:0] d0, d1, d2;
    d0 = 2'(v % 3);
    d1 = 2'((v / 3) % 3);
    d2 = 2'(v / 9);
    return {d2, d1, d0};
  endfunction

  logic [5:0] run5 [6];

  initial begin
    run5[0] = 6'b000000; run5[1] = 6'b000001; run5[2] = 6'b000010;
    run5[3] = 6'b000100; run5[4] = 6'b000101; run5[5] = 6'b000110;

    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; ack = 1'b0; tc = '0;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_done",  32'(done),  0);
    chk("rst_err",   32'(err),   0);
    reset = 1'b0;
    step();

    // tc=5 run; start stays high and tc changes during the run, both ignored
    tc = 6'b00_01_10; start = 1'b1;
    step();
    tc = 6'b00_00_01;
    chk("run5_c0", 32'(count), 0);
    chk("run5_busy0", 32'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("run5_c%0d", i), 32'(count), 32'(run5[i]));
      chk($sformatf("run5_busy%0d", i), 32'(busy), (i < 5) ? 1 : 0);
      chk($sformatf("run5_done%0d", i), 32'(done), (i == 5) ? 1 : 0);
    end
    ack = 1'b1;
    step();
    ack = 1'b0; start = 1'b0;
    chk("ack_done", 32'(done), 0);
    chk("ack_busy", 32'(busy), 0);
    chk("ack_count_held", 32'(count), 32'(6'b000110));

    // invalid digit: err pulse, count unchanged
    tc = 6'b00_00_11; start = 1'b1;
    step();
    start = 1'b0;
    chk("bad_err", 32'(err), 1);
    chk("bad_busy", 32'(busy), 0);
    chk("bad_done", 32'(done), 0);
    chk("bad_count", 32'(count), 32'(6'b000110));
    step();
    chk("bad_err_pulse", 32'(err), 0);
    chk("bad_idle", 32'(busy), 0);

    // tc=5 with a 3-cycle pause after edge k+2
    tc = 6'b00_01_10; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pz_pre", 32'(count), 32'(6'b000010));
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pz_hold", 32'(count), 32'(6'b000010));
      chk("pz_busy", 32'(busy), 1);
    end
    pause = 1'b0;
    step(); step();
    chk("pz_k7_done", 32'(done), 0);
    step();
    chk("pz_k8_done", 32'(done), 1);
    chk("pz_k8_count", 32'(count), 32'(6'b000110));
    // abort in DONE wins over ack
    abort = 1'b1; ack = 1'b1;
    step();
    abort = 1'b0; ack = 1'b0;
    chk("abd_done", 32'(done), 0);
    chk("abd_count", 32'(count), 0);

    // tc=26: full range with both carry patterns
    tc = 6'b10_10_10; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      step();
      chk($sformatf("r26_c%0d", i), 32'(count), 32'(to_b3(i)));
      chk($sformatf("r26_done%0d", i), 32'(done), (i == 26) ? 1 : 0);
      if (i == 3) chk("r26_carry1", 32'(count), 32'(6'b000100));
      if (i == 9) chk("r26_carry2", 32'(count), 32'(6'b010000));
    end
    chk("r26_final", 32'(count), 32'(6'b101010));
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("r26_idle", 32'(done), 0);

    // tc=0: straight to DONE; ack+start returns to IDLE without a new run
    tc = 6'b00_00_00; start = 1'b1;
    step();
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    chk("z_count", 32'(count), 0);
    tc = 6'b00_01_10; ack = 1'b1;
    step();
    start = 1'b0; ack = 1'b0;
    chk("z_ack_done", 32'(done), 0);
    chk("z_ack_busy", 32'(busy), 0);
    step();
    chk("z_no_run", 32'(busy), 0);

    // reset at edge k+3 of a tc=5 run
    tc = 6'b00_01_10; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("rr_pre", 32'(count), 32'(6'b000010));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_busy", 32'(busy), 0);
    chk("rr_count", 32'(count), 0);

    // abort in RUN beats pause
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    abort = 1'b1; pause = 1'b1;
    step();
    abort = 1'b0; pause = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_count", 32'(count), 0);
    step();
    chk("ab_stay_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
